// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the I/D cache-to-memory arbiter:
//                default line/address widths and the arbiter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int LINE_W_DEF = 128;   // cache-line width in bits
    localparam int ADDR_W_DEF = 16;    // byte-address width in bits

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Arbitrates an I-cache (fill only) and a D-cache (fill and
//                writeback) onto one physical-memory port. Round-robin on
//                ties, one transaction in flight, at least one IDLE cycle
//                between transactions.
//  Ports       : clk, reset                         - clock, sync active-high reset
//                icache_read/address                - I-cache fill request
//                icache_resp/rdata                  - I-cache completion + data
//                dcache_read/write/address/wdata    - D-cache request
//                dcache_resp/rdata                  - D-cache completion + data
//                pmem_read/write/address/wdata      - memory command (registered)
//                pmem_resp/rdata                    - memory completion + data
//  Revision    : 1.0  initial release
// ============================================================================
module cache_arbiter
    import arb_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_e        state_q;
    logic              last_d_q;     // 1: D-cache was served most recently
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;

    logic req_i_d;
    logic req_d_d;
    logic grant_d_d;                 // grant goes to D this cycle (IDLE only)

    // A D-cache read+write collision counts as a single D request (a write).
    always_comb begin
        req_i_d   = icache_read;
        req_d_d   = dcache_read | dcache_write;
        grant_d_d = req_d_d & (~req_i_d | ~last_d_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_d_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d_d) begin
                        state_q      <= ST_SERVE_D;
                        addr_q       <= dcache_address;
                        wdata_q      <= dcache_wdata;
                        pmem_read_q  <= ~dcache_write;
                        pmem_write_q <= dcache_write;
                    end else if (req_i_d) begin
                        state_q      <= ST_SERVE_I;
                        addr_q       <= icache_address;
                        wdata_q      <= '0;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= ST_IDLE;
                        last_d_q     <= (state_q == ST_SERVE_D);
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Command side comes purely from captured registers, so master input
    // changes after the grant never reach memory.
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Completion is a combinational pass-through to the owning master only;
    // a pmem_resp seen in IDLE reaches neither master.
    assign icache_resp  = (state_q == ST_SERVE_I) & pmem_resp;
    assign dcache_resp  = (state_q == ST_SERVE_D) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter. A transaction-level
//                model (owner / last-served / captured request) is compared
//                against the DUT every cycle; directed scenarios add literal
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int LW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_read;
    logic [AW-1:0] icache_address;
    logic          icache_resp;
    logic [LW-1:0] icache_rdata;
    logic          dcache_read;
    logic          dcache_write;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic          dcache_resp;
    logic [LW-1:0] dcache_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [LW-1:0] act,
                                input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    // owner: 0 none, 1 I-cache, 2 D-cache; last: 1 I, 2 D
    int            owner   = 0;
    int            last    = 1;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    logic          m_wr    = 1'b0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        int g;
        if (reset) begin
            owner = 0; last = 1; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
            started = 1'b1;
        end else if (owner == 0) begin
            g = 0;
            if (icache_read && (dcache_read || dcache_write)) g = (last == 2) ? 1 : 2;
            else if (dcache_read || dcache_write)              g = 2;
            else if (icache_read)                              g = 1;
            if (g == 2) begin
                m_addr = dcache_address; m_wdata = dcache_wdata; m_wr = dcache_write;
            end else if (g == 1) begin
                m_addr = icache_address; m_wr = 1'b0;
            end
            owner = g;
        end else if (pmem_resp) begin
            last  = owner;
            owner = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_pmem_read",   pmem_read,   (owner != 0) && !m_wr);
            chk("m_pmem_write",  pmem_write,  (owner != 0) && m_wr);
            chk("m_icache_resp", icache_resp, (owner == 1) && pmem_resp);
            chk("m_dcache_resp", dcache_resp, (owner == 2) && pmem_resp);
            if (owner != 0) chk("m_pmem_address", pmem_address, m_addr);
            if (owner == 2 && m_wr) chk("m_pmem_wdata", pmem_wdata, m_wdata);
            if (owner == 1) chk("m_icache_rdata", icache_rdata, pmem_rdata);
            if (owner == 2) chk("m_dcache_rdata", dcache_rdata, pmem_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from IDLE with the requests already set up;
    // memory answers on cycle 'lat' of the serve phase.
    task automatic run_txn(input int lat, input logic [LW-1:0] data, output int who,
                           output logic frd, output logic fwr,
                           output logic [AW-1:0] fad, output logic [LW-1:0] fwd);
        who = 0; frd = 1'b0; fwr = 1'b0; fad = '0; fwd = '0;
        tick();
        for (int k = 1; k <= lat; k++) begin
            pmem_resp  = (k == lat);
            pmem_rdata = (k == lat) ? data : {LW{1'b1}};
            @(negedge clk);
            if (k == 1) begin
                frd = pmem_read; fwr = pmem_write; fad = pmem_address; fwd = pmem_wdata;
            end
            if (icache_resp)      who = 1;
            else if (dcache_resp) who = 2;
            tick();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        chk("idle_gap", {pmem_read, pmem_write}, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int            who;
        int            nrd;
        int            nresp;
        int            seq[4];
        logic          frd, fwr;
        logic [AW-1:0] fad;
        logic [LW-1:0] fwd;
        logic [LW-1:0] a5;
        logic [LW-1:0] wpat;

        a5   = {16{8'hA5}};
        wpat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        reset = 1'b1; icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        do_reset();

        // Reset state, and pmem_resp in IDLE must be ignored
        @(negedge clk);
        chk("rst_outputs", {pmem_read, pmem_write, icache_resp, dcache_resp}, 4'b0000);
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("idle_resp_ignored", {icache_resp, dcache_resp}, 2'b00);
        tick();
        pmem_resp = 1'b0;

        // I read alone, 0x1230, memory answers in the 5th serve cycle
        icache_read = 1'b1; icache_address = 16'h1230;
        @(negedge clk);
        chk("i_no_cmd_in_req_cycle", pmem_read, 1'b0);
        nrd = 0; nresp = 0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            pmem_resp  = (k == 5);
            pmem_rdata = (k == 5) ? a5 : '0;
            @(negedge clk);
            if (pmem_read) nrd++;
            if (icache_resp) begin
                nresp++;
                chk("i_rdata", icache_rdata, a5);
            end
            chk("i_addr", pmem_address, 16'h1230);
            chk("i_no_dresp", dcache_resp, 1'b0);
            tick();
        end
        icache_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
        @(negedge clk);
        chk("i_read_dropped", pmem_read, 1'b0);
        chk("i_read_cycles", nrd, 5);
        chk("i_resp_cycles", nresp, 1);

        // Tie after reset: D write 0x8000 first, then I read 0x0040
        do_reset();
        icache_read = 1'b1; icache_address = 16'h0040;
        dcache_write = 1'b1; dcache_address = 16'h8000; dcache_wdata = wpat;
        run_txn(2, '0, who, frd, fwr, fad, fwd);
        chk("tie1_who", who, 2);
        chk("tie1_op", {frd, fwr}, 2'b01);
        chk("tie1_addr", fad, 16'h8000);
        chk("tie1_wdata", fwd, wpat);
        dcache_write = 1'b0;
        run_txn(1, a5, who, frd, fwr, fad, fwd);
        chk("tie2_who", who, 1);
        chk("tie2_op", {frd, fwr}, 2'b10);
        chk("tie2_addr", fad, 16'h0040);
        icache_read = 1'b0;

        // Both masters keep requesting: grants must alternate D, I, D, I
        do_reset();
        icache_read = 1'b1; icache_address = 16'h0A00;
        dcache_read = 1'b1; dcache_address = 16'h0B00;
        for (int n = 0; n < 4; n++) begin
            run_txn(n + 1, 128'h77 + n, who, frd, fwr, fad, fwd);
            seq[n] = who;
        end
        chk("rr_0", seq[0], 2);
        chk("rr_1", seq[1], 1);
        chk("rr_2", seq[2], 2);
        chk("rr_3", seq[3], 1);
        icache_read = 1'b0; dcache_read = 1'b0;
        tick();

        // D address change mid-serve must not reach memory
        dcache_read = 1'b1; dcache_address = 16'h2000;
        tick();
        dcache_address = 16'h3000;
        icache_address = 16'h5555;
        dcache_wdata   = ~wpat;
        for (int k = 1; k <= 4; k++) begin
            pmem_resp = (k == 4);
            @(negedge clk);
            chk("hold_addr", pmem_address, 16'h2000);
            tick();
        end
        dcache_read = 1'b0; pmem_resp = 1'b0;
        tick();

        // Reset during SERVE_I, then a late pmem_resp
        icache_read = 1'b1; icache_address = 16'h0500;
        tick();
        @(negedge clk);
        chk("abort_serving", pmem_read, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; icache_read = 1'b0; pmem_resp = 1'b1;
        @(negedge clk);
        chk("abort_read", pmem_read, 1'b0);
        chk("abort_iresp", icache_resp, 1'b0);
        tick();
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("abort_idle", {pmem_read, pmem_write}, 2'b00);

        // D read and write together: treated as a write
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h0100;
        dcache_wdata = wpat;
        run_txn(3, '0, who, frd, fwr, fad, fwd);
        chk("rw_op", {frd, fwr}, 2'b01);
        chk("rw_addr", fad, 16'h0100);
        chk("rw_who", who, 2);
        dcache_read = 1'b0; dcache_write = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_arbiter
`default_nettype wire
